// File: rtl/uart_send_if.sv
// rtl/uart_send_if.sv - byte write port of the buffered UART transmitter
// Producer drives the write strobe/data; transmitter returns FIFO status.
interface uart_send_if;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       fifo_full;
  logic       overflow;

  modport master (
    output wr_en,
    output wr_data,
    input  fifo_full,
    input  overflow
  );

  modport slave (
    input  wr_en,
    input  wr_data,
    output fifo_full,
    output overflow
  );
endinterface

// File: rtl/uart_send.sv
// rtl/uart_send.sv - buffered 8N1 UART transmitter with byte FIFO
// Bytes queue in a small FIFO; the FSM pops one per frame and serialises it LSB first.
module uart_send #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       sclk,
  input  logic       rst,
  input  logic [2:0] Baud_set,
  uart_send_if.slave wr_if,
  output logic       uart_tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  localparam logic [15:0] DIV_9600   = 16'(CLK_FREQ / 9600);
  localparam logic [15:0] DIV_19200  = 16'(CLK_FREQ / 19200);
  localparam logic [15:0] DIV_38400  = 16'(CLK_FREQ / 38400);
  localparam logic [15:0] DIV_57600  = 16'(CLK_FREQ / 57600);
  localparam logic [15:0] DIV_115200 = 16'(CLK_FREQ / 115200);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   div_q, div_d;
  logic [15:0]   baud_cnt_q, baud_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          full_q, full_d;
  logic          ovf_q, ovf_d;
  logic          push, pop, bit_end;
  logic [15:0]   baud_div;

  always_comb begin
    baud_div = DIV_9600;
    case (Baud_set)
      3'd1:    baud_div = DIV_19200;
      3'd2:    baud_div = DIV_38400;
      3'd3:    baud_div = DIV_57600;
      3'd4:    baud_div = DIV_115200;
      default: baud_div = DIV_9600;
    endcase
  end

  // Fullness comes from the registered count, so a pop in the same cycle cannot rescue a write.
  assign push    = wr_if.wr_en && !full_q;
  assign bit_end = (baud_cnt_q == div_q - 16'd1);

  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    div_d      = div_q;
    shift_d    = shift_q;
    baud_cnt_d = baud_cnt_q;
    pop        = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end) begin
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          done_d = 1'b1;
          if (count_q != '0) begin
            pop     = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // The divider is captured per frame so Baud_set changes only affect the next frame.
    if (pop) begin
      shift_d   = mem_q[rd_ptr_q];
      div_d     = baud_div;
      bit_idx_d = 3'd0;
    end

    if (state_q == IDLE || bit_end) baud_cnt_d = 16'd0;
    else                            baud_cnt_d = baud_cnt_q + 16'd1;
  end

  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[bit_idx_q];
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d = (count_d == FULL_CNT);
    ovf_d  = wr_if.wr_en && full_q;
    busy_d = (state_q != IDLE) || (count_q != '0);
  end

  always_ff @(posedge sclk) begin
    if (push) mem_q[wr_ptr_q] <= wr_if.wr_data;
  end

  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      div_q      <= DIV_9600;
      baud_cnt_q <= 16'd0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'd0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      full_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      div_q      <= div_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      full_q     <= full_d;
      ovf_q      <= ovf_d;
    end
  end

  assign uart_tx         = tx_q;
  assign tx_busy         = busy_q;
  assign tx_done         = done_q;
  assign wr_if.fifo_full = full_q;
  assign wr_if.overflow  = ovf_q;

endmodule

// File: tb/tb_uart_send.sv
// tb/tb_uart_send.sv - scoreboard bench for uart_send
// Expected frames are queued at write time; a line monitor decodes and compares them.
module tb_uart_send;
  localparam int CLK = 1_000_000;

  logic       sclk;
  logic       rst;
  logic [2:0] Baud_set;
  logic       uart_tx, tx_busy, tx_done;

  uart_send_if wr_if ();

  uart_send #(.CLK_FREQ(CLK), .FIFO_DEPTH(8)) dut (
    .sclk     (sclk),
    .rst      (rst),
    .Baud_set (Baud_set),
    .wr_if    (wr_if),
    .uart_tx  (uart_tx),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int div_of(input logic [2:0] code);
    int baud;
    case (code)
      3'd0:    baud = 9600;
      3'd1:    baud = 19200;
      3'd2:    baud = 38400;
      3'd3:    baud = 57600;
      3'd4:    baud = 115200;
      default: baud = 9600;
    endcase
    return CLK / baud;
  endfunction

  logic [7:0] exp_b[$];
  int         exp_div[$];
  longint     starts[$];
  longint     ends[$];
  longint     cyc = 0;
  int frames_started = 0, frames_done = 0, tx_done_cnt = 0, idle_bad = 0;
  logic last_busy_end = 1'b0, last_busy_after = 1'b1;
  bit busy_after_pending = 0;

  always @(posedge sclk) cyc <= cyc + 1;

  // Line monitor: every cycle of a frame is compared to the ideal 8N1 waveform.
  bit in_frame = 0, shape_ok, done_ok;
  int t, cur_div, bitn;
  logic [7:0] cur_b, rx_b;
  logic lvl;

  always @(negedge sclk) begin
    if (!rst) begin
      in_frame = 0;
      busy_after_pending = 0;
    end else begin
      if (busy_after_pending) begin
        last_busy_after = tx_busy;
        busy_after_pending = 0;
      end
      if (tx_done === 1'b1) tx_done_cnt++;
      if (!in_frame && uart_tx === 1'b0) begin
        chk("frame_expected", exp_b.size() > 0, 1'b1);
        if (exp_b.size() > 0) begin
          cur_b = exp_b.pop_front();
          cur_div = exp_div.pop_front();
        end else begin
          cur_b = 8'h00;
          cur_div = div_of(Baud_set);
        end
        frames_started++;
        starts.push_back(cyc);
        t = 0; in_frame = 1; shape_ok = 1; done_ok = 1; rx_b = 8'h00;
      end else if (!in_frame) begin
        if (uart_tx !== 1'b1 || tx_done !== 1'b0) idle_bad++;
      end
      if (in_frame) begin
        bitn = t / cur_div;
        if (bitn == 0) lvl = 1'b0;
        else if (bitn == 9) lvl = 1'b1;
        else lvl = cur_b[3'(bitn - 1)];
        if (uart_tx !== lvl) shape_ok = 0;
        if (tx_done !== (t == 10 * cur_div - 1)) done_ok = 0;
        if (bitn >= 1 && bitn <= 8 && (t % cur_div) == cur_div / 2) rx_b[3'(bitn - 1)] = uart_tx;
        if (t == 10 * cur_div - 1) begin
          chk("frame_shape", shape_ok, 1'b1);
          chk("tx_done_pulse", done_ok, 1'b1);
          chk("rx_byte", rx_b, cur_b);
          frames_done++;
          ends.push_back(cyc + 1);
          last_busy_end = tx_busy;
          busy_after_pending = 1;
          in_frame = 0;
        end
        t++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sclk);
      #1;
    end
  endtask

  task automatic drive(input logic [7:0] d, input int div, input bit accept);
    wr_if.wr_en = 1'b1;
    wr_if.wr_data = d;
    if (accept) begin
      exp_b.push_back(d);
      exp_div.push_back(div);
    end
    tick(1);
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (frames_done < target && n < budget) begin
      tick(1);
      n++;
    end
    chk("wait_frames", frames_done >= target, 1'b1);
  endtask

  task automatic wait_starts(input int target, input int budget);
    int n = 0;
    while (frames_started < target && n < budget) begin
      tick(1);
      n++;
    end
    chk("wait_start", frames_started >= target, 1'b1);
  endtask

  task automatic wait_room();
    int n = 0;
    while (exp_b.size() >= 8 && n < 3000) begin
      tick(1);
      n++;
    end
  endtask

  int s0, e0, d0, f0, tgt;
  logic [2:0] code;

  initial begin
    rst = 1'b0;
    Baud_set = 3'd4;
    wr_if.wr_en = 1'b0;
    wr_if.wr_data = 8'h00;
    tick(3);
    chk("rst_uart_tx", uart_tx, 1'b1);
    chk("rst_tx_busy", tx_busy, 1'b0);
    chk("rst_tx_done", tx_done, 1'b0);
    chk("rst_fifo_full", wr_if.fifo_full, 1'b0);
    chk("rst_overflow", wr_if.overflow, 1'b0);
    rst = 1'b1;
    tick(2);

    // Single 0x55 frame at 115200: two-cycle latency, one tx_done, busy drop timing
    d0 = tx_done_cnt;
    drive(8'h55, div_of(3'd4), 1);
    wr_if.wr_en = 1'b0;
    tick(1);
    chk("latency_n1_high", uart_tx, 1'b1);
    tick(1);
    chk("latency_n2_low", uart_tx, 1'b0);
    wait_frames(1, 200);
    tick(3);
    chk("busy_last_stop", last_busy_end, 1'b1);
    chk("busy_after_stop", last_busy_after, 1'b0);
    chk("single_done_cnt", tx_done_cnt - d0, 1);

    // Three back-to-back frames at 9600
    Baud_set = 3'd0;
    s0 = starts.size(); e0 = ends.size(); d0 = tx_done_cnt; tgt = frames_done + 3;
    drive(8'hA3, div_of(3'd0), 1);
    drive(8'h0F, div_of(3'd0), 1);
    drive(8'hFF, div_of(3'd0), 1);
    wr_if.wr_en = 1'b0;
    wait_frames(tgt, 4000);
    chk("b2b_gap1", starts[s0 + 1], ends[e0]);
    chk("b2b_gap2", starts[s0 + 2], ends[e0 + 1]);
    chk("b2b_done_cnt", tx_done_cnt - d0, 3);
    tick(3);

    // Ten writes from idle: one to the shifter, eight fill the FIFO, the tenth is dropped
    Baud_set = 3'd4;
    f0 = frames_started; tgt = frames_done + 9;
    for (int i = 0; i < 10; i++) begin
      drive(8'($urandom), div_of(3'd4), i < 9);
      if (i == 8) chk("fifo_full_after9", wr_if.fifo_full, 1'b1);
      if (i == 9) chk("overflow_pulse", wr_if.overflow, 1'b1);
    end
    wr_if.wr_en = 1'b0;
    tick(1);
    chk("overflow_one_cycle", wr_if.overflow, 1'b0);
    wait_frames(tgt, 1500);
    tick(200);
    chk("nine_frames_only", frames_started - f0, 9);

    // Baud change during DATA of frame 1 only affects frame 2
    f0 = frames_started; tgt = frames_done + 2;
    drive(8'($urandom), div_of(3'd4), 1);
    drive(8'($urandom), div_of(3'd1), 1);
    wr_if.wr_en = 1'b0;
    wait_starts(f0 + 1, 100);
    tick(20);
    Baud_set = 3'd1;
    wait_frames(tgt, 1200);
    Baud_set = 3'd4;
    tick(3);

    // Async reset during data bit 3 with two bytes still queued
    f0 = frames_started;
    for (int i = 0; i < 3; i++) drive(8'($urandom), div_of(3'd4), 1);
    wr_if.wr_en = 1'b0;
    wait_starts(f0 + 1, 100);
    tick(36);
    #2;
    rst = 1'b0;
    #1;
    chk("midreset_tx_high", uart_tx, 1'b1);
    chk("midreset_busy", tx_busy, 1'b0);
    chk("midreset_full", wr_if.fifo_full, 1'b0);
    exp_b.delete();
    exp_div.delete();
    tick(2);
    #2;
    rst = 1'b1;
    f0 = frames_started;
    tick(300);
    chk("postreset_no_frames", frames_started - f0, 0);
    chk("postreset_busy", tx_busy, 1'b0);
    chk("postreset_tx_idle", uart_tx, 1'b1);

    // Randomised bursts at random baud codes, including the aliased 5..7
    for (int b = 0; b < 4; b++) begin
      code = 3'($urandom_range(0, 7));
      Baud_set = code;
      tgt = frames_done + 8;
      for (int i = 0; i < 8; i++) begin
        wait_room();
        tick($urandom_range(0, 3));
        drive(8'($urandom), div_of(code), 1);
        wr_if.wr_en = 1'b0;
      end
      wait_frames(tgt, 12000);
      tick(3);
    end

    // Full byte sweep at 115200, decoded by the line monitor
    Baud_set = 3'd4;
    tgt = frames_done + 256;
    for (int i = 0; i < 256; i++) begin
      wait_room();
      drive(8'(i), div_of(3'd4), 1);
      wr_if.wr_en = 1'b0;
    end
    wait_frames(tgt, 25000);
    tick(20);

    chk("scoreboard_drained", exp_b.size(), 0);
    chk("idle_line_clean", idle_bad, 0);
    chk("done_per_frame", tx_done_cnt, frames_done);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
